// File: rtl/serial_port.sv
// serial_port: memory-mapped 8N1 UART for the SCAMP I/O bus.
// The data register at BASE_ADDR queues TX bytes on write and returns the
// received byte on read; the status register at BASE_ADDR+1 reports
// {overrun, tx_idle, ~fifo_full, rx_valid}.
// Build macro SERIAL_LOOPBACK_EN: feed the TX serialiser into the RX
// synchroniser and park the tx pin high.
module serial_port #(
   parameter int BASE_ADDR  = 136,
   parameter int CLK_DIV    = 104,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset_bar,
   input  logic [15:0] addr,
   input  logic [15:0] bus_wr,
   input  logic        DI,
   input  logic        DO,
   output logic [15:0] bus_rd,
   output logic        bus_rd_en,
   output logic        tx,
   input  logic        rx
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DATA_ADDR = 16'(BASE_ADDR);
   localparam logic [15:0] STAT_ADDR = 16'(BASE_ADDR + 1);
   localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic wsel, rselD, rselS;
   logic wsel_q, rselD_q, rselS_q;
   logic push, pop, dataReadEnd, statReadEnd;
   logic fifoEmpty, fifoFull, txIdle;
   logic [AW:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
   logic [7:0] mem_q [FIFO_DEPTH];

   state_t txState_q, txState_d;
   logic [15:0] txBaud_q, txBaud_d;
   logic [2:0] txBit_q, txBit_d;
   logic [7:0] txShift_q, txShift_d;
   logic txOut_q, txOut_d;

   logic rxSrc, sync1_q, sync2_q, rxPrev_q, fallEdge, frameOk;
   state_t rxState_q, rxState_d;
   logic [15:0] rxBaud_q, rxBaud_d;
   logic [2:0] rxBit_q, rxBit_d;
   logic [7:0] rxShift_q, rxShift_d;
   logic [7:0] rxByte_q, rxByte_d;
   logic rxValid_q, rxValid_d, overrun_q, overrun_d;

   logic unusedWrHigh;
   assign unusedWrHigh = ^bus_wr[15:8];

   assign wsel  = DI & (addr == DATA_ADDR);
   assign rselD = DO & (addr == DATA_ADDR);
   assign rselS = DO & (addr == STAT_ADDR);

   assign push        = wsel & ~wsel_q & ~fifoFull;
   assign dataReadEnd = rselD_q & ~rselD;
   assign statReadEnd = rselS_q & ~rselS;

   assign fifoEmpty = (wrPtr_q == rdPtr_q);
   assign fifoFull  = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                      (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
   assign txIdle    = (txState_q == IDLE) & fifoEmpty;
   assign fallEdge  = rxPrev_q & ~sync2_q;

`ifdef SERIAL_LOOPBACK_EN
   logic unusedRxPin;
   assign unusedRxPin = rx;
   assign tx    = 1'b1;
   assign rxSrc = txOut_q;
`else
   assign tx    = txOut_q;
   assign rxSrc = rx;
`endif

   // Read mux: the bus is driven only while one of our registers is selected
   always_comb begin
      bus_rd_en = rselD | rselS;
      bus_rd    = 16'h0000;
      if (rselD)
         bus_rd = {8'h00, rxByte_q};
      else if (rselS)
         bus_rd = {12'h000, overrun_q, txIdle, ~fifoFull, rxValid_q};
   end

   // TX FIFO storage; entries need no reset since the pointers define validity
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wrPtr_q[AW-1:0]] <= bus_wr[7:0];
   end

   // TX serialiser: pop and start a frame whenever bytes wait, frames back to back
   always_comb begin
      txState_d = txState_q;
      txBaud_d  = txBaud_q;
      txBit_d   = txBit_q;
      txShift_d = txShift_q;
      txOut_d   = txOut_q;
      pop       = 1'b0;
      case (txState_q)
         IDLE: begin
            if (!fifoEmpty) begin
               pop       = 1'b1;
               txState_d = START;
               txShift_d = mem_q[rdPtr_q[AW-1:0]];
               txBaud_d  = '0;
               txOut_d   = 1'b0;
            end
         end
         START: begin
            if (txBaud_q == BAUD_LAST) begin
               txState_d = DATA;
               txBaud_d  = '0;
               txBit_d   = '0;
               txOut_d   = txShift_q[0];
            end else
               txBaud_d = txBaud_q + 16'd1;
         end
         DATA: begin
            if (txBaud_q == BAUD_LAST) begin
               txBaud_d = '0;
               if (txBit_q == 3'd7) begin
                  txState_d = STOP;
                  txOut_d   = 1'b1;
               end else begin
                  txBit_d   = txBit_q + 3'd1;
                  txShift_d = {1'b0, txShift_q[7:1]};
                  txOut_d   = txShift_q[1];
               end
            end else
               txBaud_d = txBaud_q + 16'd1;
         end
         STOP: begin
            if (txBaud_q == BAUD_LAST) begin
               txBaud_d = '0;
               if (!fifoEmpty) begin
                  pop       = 1'b1;
                  txState_d = START;
                  txShift_d = mem_q[rdPtr_q[AW-1:0]];
                  txOut_d   = 1'b0;
               end else
                  txState_d = IDLE;
            end else
               txBaud_d = txBaud_q + 16'd1;
         end
         default: txState_d = IDLE;
      endcase
      wrPtr_d = wrPtr_q + {{AW{1'b0}}, push};
      rdPtr_d = rdPtr_q + {{AW{1'b0}}, pop};
   end

   // RX deserialiser: mid-bit sampling after a synchronised falling edge
   always_comb begin
      rxState_d = rxState_q;
      rxBaud_d  = rxBaud_q;
      rxBit_d   = rxBit_q;
      rxShift_d = rxShift_q;
      frameOk   = 1'b0;
      case (rxState_q)
         IDLE: begin
            if (fallEdge) begin
               rxState_d = START;
               rxBaud_d  = '0;
            end
         end
         START: begin
            if (rxBaud_q == HALF_LAST) begin
               rxBaud_d  = '0;
               rxBit_d   = '0;
               rxState_d = sync2_q ? IDLE : DATA;
            end else
               rxBaud_d = rxBaud_q + 16'd1;
         end
         DATA: begin
            if (rxBaud_q == BAUD_LAST) begin
               rxBaud_d  = '0;
               rxShift_d = {sync2_q, rxShift_q[7:1]};
               if (rxBit_q == 3'd7)
                  rxState_d = STOP;
               else
                  rxBit_d = rxBit_q + 3'd1;
            end else
               rxBaud_d = rxBaud_q + 16'd1;
         end
         STOP: begin
            if (rxBaud_q == BAUD_LAST) begin
               rxBaud_d  = '0;
               rxState_d = IDLE;
               frameOk   = sync2_q;
            end else
               rxBaud_d = rxBaud_q + 16'd1;
         end
         default: rxState_d = IDLE;
      endcase
   end

   // Holding register: reads clear flags at end of access, a new byte beats a clear
   always_comb begin
      rxValid_d = rxValid_q;
      overrun_d = overrun_q;
      rxByte_d  = rxByte_q;
      if (dataReadEnd)
         rxValid_d = 1'b0;
      if (statReadEnd)
         overrun_d = 1'b0;
      if (frameOk) begin
         if (rxValid_q && !dataReadEnd)
            overrun_d = 1'b1;
         else begin
            rxByte_d  = rxShift_q;
            rxValid_d = 1'b1;
         end
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_bar) begin
         wsel_q    <= 1'b0;
         rselD_q   <= 1'b0;
         rselS_q   <= 1'b0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         txState_q <= IDLE;
         txBaud_q  <= '0;
         txBit_q   <= '0;
         txShift_q <= '0;
         txOut_q   <= 1'b1;
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         rxPrev_q  <= 1'b1;
         rxState_q <= IDLE;
         rxBaud_q  <= '0;
         rxBit_q   <= '0;
         rxShift_q <= '0;
         rxByte_q  <= '0;
         rxValid_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         wsel_q    <= wsel;
         rselD_q   <= rselD;
         rselS_q   <= rselS;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         txState_q <= txState_d;
         txBaud_q  <= txBaud_d;
         txBit_q   <= txBit_d;
         txShift_q <= txShift_d;
         txOut_q   <= txOut_d;
         sync1_q   <= rxSrc;
         sync2_q   <= sync1_q;
         rxPrev_q  <= sync2_q;
         rxState_q <= rxState_d;
         rxBaud_q  <= rxBaud_d;
         rxBit_q   <= rxBit_d;
         rxShift_q <= rxShift_d;
         rxByte_q  <= rxByte_d;
         rxValid_q <= rxValid_d;
         overrun_q <= overrun_d;
      end
   end
endmodule

// File: tb/tb_serial_port.sv
// tb_serial_port: directed and randomized checks of the serial_port UART,
// with a frame-level TX monitor and a flag-level model of the RX register.
module tb_serial_port;
   localparam int CLK_DIV    = 4;
   localparam int FIFO_DEPTH = 4;
   localparam logic [15:0] DATA_ADDR = 16'd136;
   localparam logic [15:0] STAT_ADDR = 16'd137;

   logic        clk = 1'b0;
   logic        reset_bar;
   logic [15:0] addr;
   logic [15:0] bus_wr;
   logic        DI;
   logic        DO;
   logic [15:0] bus_rd;
   logic        bus_rd_en;
   logic        tx;
   logic        rx;

   int vectors = 0;
   int miscompares = 0;
   int cycle = 0;

   logic [7:0] monByte[$];
   logic       monStop[$];
   int         monStart[$];

   serial_port #(
      .BASE_ADDR(136),
      .CLK_DIV(CLK_DIV),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk),
      .reset_bar(reset_bar),
      .addr(addr),
      .bus_wr(bus_wr),
      .DI(DI),
      .DO(DO),
      .bus_rd(bus_rd),
      .bus_rd_en(bus_rd_en),
      .tx(tx),
      .rx(rx)
   );

   // Free-running clock and cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) cycle <= cycle + 1;

   // Safety net so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // TX line monitor: decodes 8N1 frames by sampling each bit in its middle
   initial begin : txMonitor
      logic [7:0] b;
      int t0;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            t0 = cycle;
            repeat (CLK_DIV / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (CLK_DIV) @(negedge clk);
               b[k] = tx;
            end
            repeat (CLK_DIV) @(negedge clk);
            monByte.push_back(b);
            monStop.push_back(tx);
            monStart.push_back(t0);
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // One-cycle CPU write strobe
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] data);
      @(posedge clk);
      #1;
      addr   = a;
      bus_wr = data;
      DI     = 1'b1;
      @(posedge clk);
      #1;
      DI = 1'b0;
   endtask

   task automatic readBus(input logic [15:0] a, output logic [15:0] data, output logic en);
      @(posedge clk);
      #1;
      addr = a;
      DO   = 1'b1;
      @(negedge clk);
      data = bus_rd;
      en   = bus_rd_en;
      @(posedge clk);
      #1;
      DO = 1'b0;
   endtask

   task automatic checkReg(input string tag, input logic [15:0] a, input logic [15:0] expected);
      logic [15:0] d;
      logic e;
      readBus(a, d, e);
      checkOutput({tag, " bus_rd_en"}, {15'd0, e}, 16'd1);
      checkOutput(tag, d, expected);
   endtask

   task automatic sendRx(input logic [7:0] b, input logic stopBit);
      @(posedge clk);
      #1 rx = 1'b0;
      for (int k = 0; k < 8; k++) begin
         repeat (CLK_DIV) @(posedge clk);
         #1 rx = b[k];
      end
      repeat (CLK_DIV) @(posedge clk);
      #1 rx = stopBit;
      repeat (CLK_DIV) @(posedge clk);
      #1 rx = 1'b1;
      repeat (2 * CLK_DIV) @(posedge clk);
   endtask

   task automatic waitFrames(input int n, input int budget);
      int left = budget;
      while (monByte.size() < n && left > 0) begin
         @(negedge clk);
         left--;
      end
      checkOutput("frame arrival", {15'd0, monByte.size() >= n}, 16'd1);
   endtask

   task automatic clearMonitor();
      monByte.delete();
      monStop.delete();
      monStart.delete();
   endtask

   // Directed sequence followed by randomized TX bursts and RX traffic
   initial begin
      logic [7:0] expBits;
      logic [7:0] expQ[$];
      logic [15:0] d;
      logic e;
      logic [7:0] b;
      int n;
      int lowCount;
      logic mValid, mOverrun;
      logic [7:0] mByte;

      reset_bar = 1'b0;
      addr      = 16'h0000;
      bus_wr    = 16'h0000;
      DI        = 1'b0;
      DO        = 1'b0;
      rx        = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset tx", {15'd0, tx}, 16'd1);
      checkOutput("reset bus_rd_en", {15'd0, bus_rd_en}, 16'd0);
      checkOutput("reset bus_rd", bus_rd, 16'h0000);
      reset_bar = 1'b1;
      checkReg("reset status", STAT_ADDR, 16'h0006);
      readBus(16'h0040, d, e);
      checkOutput("unselected bus_rd_en", {15'd0, e}, 16'd0);
      checkOutput("unselected bus_rd", d, 16'h0000);

`ifdef SERIAL_LOOPBACK_EN
      expQ = {8'h5A, 8'($urandom), 8'($urandom)};
      foreach (expQ[i]) begin
         applyStimulus(DATA_ADDR, {8'($urandom), expQ[i]});
         lowCount = 0;
         repeat (15 * CLK_DIV) begin
            @(negedge clk);
            if (tx !== 1'b1) lowCount++;
         end
         checkOutput("loopback tx pin parked", 16'(lowCount), 16'd0);
         checkReg("loopback status", STAT_ADDR, 16'h0007);
         checkReg("loopback data", DATA_ADDR, {8'h00, expQ[i]});
      end
`else
      // Single frame, checked cycle by cycle
      applyStimulus(DATA_ADDR, 16'h1255);
      @(negedge clk);
      checkOutput("tx before start", {15'd0, tx}, 16'd1);
      repeat (CLK_DIV) begin
         @(negedge clk);
         checkOutput("tx start bit", {15'd0, tx}, 16'd0);
      end
      expBits = 8'h55;
      for (int k = 0; k < 8; k++) begin
         repeat (CLK_DIV) begin
            @(negedge clk);
            checkOutput("tx data bit", {15'd0, tx}, {15'd0, expBits[k]});
         end
      end
      repeat (CLK_DIV) begin
         @(negedge clk);
         checkOutput("tx stop bit", {15'd0, tx}, 16'd1);
      end
      checkReg("status after frame", STAT_ADDR, 16'h0006);
      repeat (4 * CLK_DIV) @(posedge clk);
      clearMonitor();

      // Reset in the middle of a frame with a second byte waiting
      applyStimulus(DATA_ADDR, 16'h00F0);
      applyStimulus(DATA_ADDR, 16'h000F);
      repeat (3 * CLK_DIV) @(posedge clk);
      #1;
      checkOutput("tx low mid frame", {15'd0, tx}, 16'd0);
      reset_bar = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("tx after mid-frame reset", {15'd0, tx}, 16'd1);
      reset_bar = 1'b1;
      checkReg("status after mid-frame reset", STAT_ADDR, 16'h0006);
      lowCount = 0;
      repeat (12 * CLK_DIV) begin
         @(negedge clk);
         if (tx !== 1'b1) lowCount++;
      end
      checkOutput("tx quiet after reset", 16'(lowCount), 16'd0);
      clearMonitor();

      // FIFO overflow: one byte in flight plus FIFO_DEPTH queued, the rest dropped
      for (int i = 1; i <= 5; i++)
         applyStimulus(DATA_ADDR, 16'(i));
      checkReg("status fifo full", STAT_ADDR, 16'h0000);
      applyStimulus(DATA_ADDR, 16'h0006);
      waitFrames(5, 500);
      repeat (15 * CLK_DIV) @(posedge clk);
      checkOutput("fifo frame count", 16'(monByte.size()), 16'd5);
      for (int i = 0; i < 5 && i < monByte.size(); i++) begin
         checkOutput("fifo frame byte", {8'h00, monByte[i]}, 16'(i + 1));
         checkOutput("fifo frame stop", {15'd0, monStop[i]}, 16'd1);
         if (i > 0)
            checkOutput("fifo frame spacing", 16'(monStart[i] - monStart[i-1]), 16'(10 * CLK_DIV));
      end
      checkReg("status fifo drained", STAT_ADDR, 16'h0006);
      clearMonitor();

      // Random bursts: bytes arriving while the FIFO has room are sent in order
      repeat (3) begin
         n = $urandom_range(1, FIFO_DEPTH + 3);
         expQ.delete();
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (i <= FIFO_DEPTH) expQ.push_back(b);
            applyStimulus(DATA_ADDR, {8'($urandom), b});
         end
         waitFrames(expQ.size(), 600);
         repeat (15 * CLK_DIV) @(posedge clk);
         checkOutput("burst frame count", 16'(monByte.size()), 16'(expQ.size()));
         for (int i = 0; i < expQ.size() && i < monByte.size(); i++) begin
            checkOutput("burst frame byte", {8'h00, monByte[i]}, {8'h00, expQ[i]});
            checkOutput("burst frame stop", {15'd0, monStop[i]}, 16'd1);
            if (i > 0)
               checkOutput("burst frame spacing", 16'(monStart[i] - monStart[i-1]), 16'(10 * CLK_DIV));
         end
         clearMonitor();
      end

      // Receive path, directed
      sendRx(8'hA3, 1'b1);
      checkReg("rx status valid", STAT_ADDR, 16'h0007);
      checkReg("rx data", DATA_ADDR, 16'h00A3);
      checkReg("rx status cleared", STAT_ADDR, 16'h0006);

      sendRx(8'h11, 1'b1);
      sendRx(8'h22, 1'b1);
      checkReg("overrun status", STAT_ADDR, 16'h000F);
      checkReg("overrun data keeps first", DATA_ADDR, 16'h0011);
      checkReg("overrun cleared", STAT_ADDR, 16'h0006);

      @(posedge clk);
      #1 rx = 1'b0;
      @(posedge clk);
      #1 rx = 1'b1;
      repeat (12 * CLK_DIV) @(posedge clk);
      checkReg("glitch ignored", STAT_ADDR, 16'h0006);

      sendRx(8'h3C, 1'b0);
      checkReg("framing error status", STAT_ADDR, 16'h0006);
      checkReg("framing error data", DATA_ADDR, 16'h0011);

      // Random receive traffic against a flag-level model of the holding register
      mValid   = 1'b0;
      mOverrun = 1'b0;
      mByte    = 8'h11;
      repeat (18) begin
         case ($urandom_range(0, 2))
            0: begin
               b = 8'($urandom);
               sendRx(b, 1'b1);
               if (mValid)
                  mOverrun = 1'b1;
               else begin
                  mByte  = b;
                  mValid = 1'b1;
               end
            end
            1: begin
               checkReg("random data read", DATA_ADDR, {8'h00, mByte});
               mValid = 1'b0;
            end
            default: begin
               checkReg("random status read", STAT_ADDR,
                        {12'h000, mOverrun, 1'b1, 1'b1, mValid});
               mOverrun = 1'b0;
            end
         endcase
      end
      checkReg("final status", STAT_ADDR, {12'h000, mOverrun, 1'b1, 1'b1, mValid});
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/serial_port.md
Name: serial_port

Overview:
- Memory-mapped UART device on the SCAMP CPU I/O bus, sitting directly downstream of the CPU's device-strobe interface (addr, DI, DO).
- CPU writes push bytes into a TX FIFO that is serialised 8N1 onto `tx`.
- Bytes received on `rx` are held in a one-byte holding register for CPU reads.
- A status register exposes FIFO and receiver state, so firmware can poll before each access.

Parameters:
- BASE_ADDR, 136, I/O address of the data register; the status register is at BASE_ADDR+1.
- CLK_DIV, 104, clock cycles per serial bit; legal range 4..65535.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- reset_bar  in  1  synchronous active-low reset.
- addr  in  16  CPU I/O address.
- bus_wr  in  16  CPU write data; only bits [7:0] are used.
- DI  in  1  device-input strobe: CPU is writing bus_wr to addr.
- DO  in  1  device-output strobe: CPU is reading from addr.
- bus_rd  out  16  read data; 0 when bus_rd_en is low.
- bus_rd_en  out  1  high while this block drives the read bus.
- tx  out  1  serial out, idle high.
- rx  in  1  serial in, asynchronous, idle high.

Behaviour:
- Reset values (reset_bar low at a clk edge):
  - tx=1, FIFO empty, TX FSM in IDLE.
  - RX FSM in IDLE, rx_valid=0, overrun=0.
  - bus_rd_en=0, bus_rd=0.
  - Reset mid-frame aborts the frame immediately; tx goes to 1 on the next edge.
- Address decode:
  - wsel = DI & (addr==BASE_ADDR).
  - rsel_d = DO & (addr==BASE_ADDR).
  - rsel_s = DO & (addr==BASE_ADDR+1).
- Writes:
  - The push happens on the first cycle wsel is high (rising detect via a registered copy), so one push per access however long DI is held.
  - If the FIFO is full, the byte is dropped and there is no other effect.
- Reads:
  - Combinational. bus_rd_en = rsel_d | rsel_s.
  - Data read: bus_rd = {8'h00, rx_byte}.
  - Status read: bus_rd = {12'h000, overrun, tx_idle, ~fifo_full, rx_valid}.
  - Side effects take place on the first cycle after the select deasserts (end of access):
    - a data read clears rx_valid;
    - a status read clears overrun.
  - Data is therefore stable for the whole access.
- TX FIFO:
  - Circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full/empty are decided by pointer MSB compare.
  - A simultaneous push and pop in the same cycle is legal when not empty.
  - A push into an empty FIFO while the FSM is IDLE is popped on the following edge.
- TX FSM (IDLE, START, DATA, STOP), with a bit counter 0..7 and a baud counter 0..CLK_DIV-1:
  - IDLE → START when the FIFO is not empty: pop the byte and drive tx=0 on the same edge.
  - Each state lasts exactly CLK_DIV cycles.
  - DATA sends bits LSB first.
  - STOP drives tx=1 for CLK_DIV cycles, then goes to START if the FIFO is not empty, else IDLE. Back-to-back frames have no extra idle cycle.
  - tx_idle = (state==IDLE) & fifo_empty.
- RX:
  - rx passes through a 2-flop synchroniser.
  - RX FSM (IDLE, START, DATA, STOP):
    - IDLE → START on a synchronised falling edge.
    - START: sample at CLK_DIV/2 cycles. If the sample is high, it was a glitch: return to IDLE.
    - DATA: sample each bit every CLK_DIV cycles, LSB first.
    - STOP: sample once. If high, the frame is valid.
  - On a valid frame:
    - if rx_valid is already set, set overrun and discard the new byte (rx_byte keeps the old byte);
    - otherwise load rx_byte and set rx_valid.
  - A stop bit of 0 is a framing error: discard the byte and wait in IDLE until the line is high, then re-arm.
  - If a data-read clear and a new-byte load fall on the same edge, the load wins: rx_valid stays 1 with the new byte.

Optional Feature:
- SERIAL_LOOPBACK_EN defined:
  - the RX synchroniser input is taken from the internal TX serialiser output instead of the rx pin;
  - the tx pin is held at 1.
- Not defined: normal pin operation, and no loopback logic is present.

Test Plan:
- Reset: hold reset_bar=0 for 3 clks with rx=1 → tx=1, bus_rd_en=0; a status read returns 16'h0006.
- TX frame (CLK_DIV=4): one-cycle write of 16'h1255 to addr 136 → tx low for cycles 2-5 after the strobe, then the bit stream 1,0,1,0,1,0,1,0 at 4 cycles each, then high; the status tx_idle bit returns to 1 after the stop bit.
- FIFO full (FIFO_DEPTH=4, CLK_DIV=4):
  - write 6 bytes 0x01..0x06 back-to-back → status ~fifo_full bit reads 0 after the 5th write;
  - exactly 5 frames appear (0x01..0x05), sent consecutively;
  - 0x06 is lost.
- RX receive: drive the 8N1 frame 0xA3 on rx → status reads 16'h0007; a data read returns 16'h00A3; the following status read returns 16'h0006.
- Overrun: send 0x11 then 0x22 without reading → status bit3=1, data read returns 0x11; after the status read, bit3=0.
- Framing and glitch:
  - a 1-cycle low glitch on rx produces no byte;
  - a frame with stop bit 0 produces no byte and leaves rx_valid=0;
  - with SERIAL_LOOPBACK_EN, writing 0x5A yields rx_valid=1 and a data read returns 0x5A.
